p4_router_queue_occupancy: RTL and testbench

P4_ROUTER_QUEUE_OCCUPANCY -- requirements
Module: p4_router_queue_occupancy

---
 rtl/p4_router_pkg.sv | 30 +++
 rtl/axis_int.sv | 17 +
 rtl/p4_router_queue_counter.sv | 52 +++++
 rtl/p4_router_queue_occupancy.sv | 138 +++++++++++++
 tb/tb_p4_router_queue_occupancy.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/p4_router_pkg.sv
// Shared types for the P4 router queue-occupancy slice: per-port queue count,
// queue-index type and the decoded notification-beat record.
package p4_router_pkg;

  localparam int NUM_QUEUES_PER_EGR_PORT = 4;
  localparam int QUEUE_IDX_W             = 8;

  typedef logic [QUEUE_IDX_W-1:0] queue_idx_t;

  typedef struct packed {
    logic       beat;      // tvalid && tready
    logic       pkt_end;   // handshake on the last beat of a packet
    logic       in_range;
    queue_idx_t idx;
  } queue_evt_t;

  function automatic queue_evt_t decode_evt(input logic       tvalid,
                                            input logic       tready,
                                            input logic       tlast,
                                            input queue_idx_t idx,
                                            input queue_idx_t num_queues);
    queue_evt_t e;
    e.beat     = tvalid && tready;
    e.pkt_end  = e.beat && tlast;
    e.in_range = (idx < num_queues);
    e.idx      = idx;
    return e;
  endfunction

endpackage

// File: rtl/axis_int.sv
// AXI4-Stream bundle used for enqueue/dequeue notifications; the Monitor
// modport observes a stream without driving any of it.
interface AXIS_int #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 8
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tlast;

  modport Master  (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport Slave   (input tvalid, tdata, tkeep, tuser, tlast, output tready);
  modport Monitor (input tvalid, tready, tdata, tkeep, tuser, tlast);
endinterface

// File: rtl/p4_router_queue_counter.sv
// Saturating up/down occupancy counter for one queue; inc and dec in the same
// cycle net against each other before saturation is applied.
module p4_router_queue_counter #(
  parameter int WIDTH = 12,
  parameter int AMT_W = 1
) (
  input  logic             clk,
  input  logic             sreset,
  input  logic             inc,
  input  logic             dec,
  input  logic [AMT_W-1:0] inc_amt,
  input  logic [AMT_W-1:0] dec_amt,
  output logic [WIDTH-1:0] cnt,
  output logic             zero,
  output logic             ovf,
  output logic             unf
);

  localparam int SUM_W = ((WIDTH > AMT_W) ? WIDTH : AMT_W) + 2;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'({WIDTH{1'b1}});

  logic signed [SUM_W-1:0] sum_p0;
  logic        [WIDTH-1:0] next_p0;

  function automatic logic [WIDTH-1:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])  return '0;
    else if (v > MAX_S) return '1;
    else             return v[WIDTH-1:0];
  endfunction

  always_comb begin
    sum_p0 = $signed(SUM_W'(cnt));
    if (inc) sum_p0 = sum_p0 + $signed(SUM_W'(inc_amt));
    if (dec) sum_p0 = sum_p0 - $signed(SUM_W'(dec_amt));
  end

  assign next_p0 = saturate(sum_p0);
  assign ovf     = (sum_p0 > MAX_S);
  assign unf     = sum_p0[SUM_W-1];

  // p0 -> p1: registered count and empty flag
  always_ff @(posedge clk) begin
    if (sreset) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else begin
      cnt  <= next_p0;
      zero <= (next_p0 == '0);
    end
  end

endmodule

// File: rtl/p4_router_queue_occupancy.sv
// Per-queue packet occupancy tracker fed by enqueue/dequeue notification streams.
// Optional byte counters are built when P4_ROUTER_QUEUE_BYTE_COUNT_EN is defined.
module p4_router_queue_occupancy
  import p4_router_pkg::*;
#(
  parameter int NUM_EGR_PORTS  = 0,
  parameter int NUM_QUEUES     = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT,
  parameter int PKT_CNT_WIDTH  = 12,
  parameter int BYTE_CNT_WIDTH = 24
) (
  input  logic                                clk,
  input  logic                                sreset,
  AXIS_int.Monitor                            enqueue_notification,
  AXIS_int.Monitor                            dequeue_notification,
  output logic [NUM_QUEUES-1:0]               queue_empty,
  output logic [NUM_QUEUES*PKT_CNT_WIDTH-1:0] queue_pkt_cnt,
`ifdef P4_ROUTER_QUEUE_BYTE_COUNT_EN
  output logic [NUM_QUEUES*BYTE_CNT_WIDTH-1:0] queue_byte_cnt,
`endif
  output logic                                err_overflow,
  output logic                                err_underflow,
  output logic                                err_bad_queue
);

  localparam int         QW        = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam queue_idx_t NQ_LIMIT  = queue_idx_t'(NUM_QUEUES);

  if (NUM_EGR_PORTS <= 0) begin : g_bad_ports
    $error("p4_router_queue_occupancy: NUM_EGR_PORTS must be > 0");
  end
  if (NUM_QUEUES >= (1 << QUEUE_IDX_W)) begin : g_bad_nq
    $error("p4_router_queue_occupancy: NUM_QUEUES exceeds queue_idx_t range");
  end
  if (BYTE_CNT_WIDTH < 1) begin : g_bad_bytew
    $error("p4_router_queue_occupancy: BYTE_CNT_WIDTH must be >= 1");
  end

  queue_evt_t            enq_evt_p0, deq_evt_p0;
  logic                  bad_p0, ovf_any_p0, unf_any_p0;
  logic [NUM_QUEUES-1:0] pkt_ovf_p0, pkt_unf_p0;
  logic                  unused_notif;

  assign enq_evt_p0 = decode_evt(enqueue_notification.tvalid, enqueue_notification.tready,
                                 enqueue_notification.tlast,
                                 queue_idx_t'(enqueue_notification.tuser[QW-1:0]), NQ_LIMIT);
  assign deq_evt_p0 = decode_evt(dequeue_notification.tvalid, dequeue_notification.tready,
                                 dequeue_notification.tlast,
                                 queue_idx_t'(dequeue_notification.tuser[QW-1:0]), NQ_LIMIT);

  // Out-of-range packet ends never reach a counter: no queue id matches them.
  assign bad_p0 = (enq_evt_p0.pkt_end && !enq_evt_p0.in_range) ||
                  (deq_evt_p0.pkt_end && !deq_evt_p0.in_range);

  assign unused_notif = ^{enqueue_notification.tdata, enqueue_notification.tkeep,
                          enqueue_notification.tuser, dequeue_notification.tdata,
                          dequeue_notification.tkeep, dequeue_notification.tuser,
                          enq_evt_p0.beat, deq_evt_p0.beat};

`ifdef P4_ROUTER_QUEUE_BYTE_COUNT_EN
  localparam int BYTE_AMT_W = 16;

  logic [BYTE_AMT_W-1:0] enq_bytes_p0, deq_bytes_p0;
  logic [NUM_QUEUES-1:0] byte_ovf_p0, byte_unf_p0;

  assign enq_bytes_p0 = BYTE_AMT_W'($countones(enqueue_notification.tkeep));
  assign deq_bytes_p0 = BYTE_AMT_W'($countones(dequeue_notification.tkeep));
`endif

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
    localparam queue_idx_t QID = queue_idx_t'(q);
    logic pkt_inc, pkt_dec;

    assign pkt_inc = enq_evt_p0.pkt_end && (enq_evt_p0.idx == QID);
    assign pkt_dec = deq_evt_p0.pkt_end && (deq_evt_p0.idx == QID);

    p4_router_queue_counter #(
      .WIDTH (PKT_CNT_WIDTH),
      .AMT_W (1)
    ) u_pkt_cnt (
      .clk     (clk),
      .sreset  (sreset),
      .inc     (pkt_inc),
      .dec     (pkt_dec),
      .inc_amt (1'b1),
      .dec_amt (1'b1),
      .cnt     (queue_pkt_cnt[q*PKT_CNT_WIDTH +: PKT_CNT_WIDTH]),
      .zero    (queue_empty[q]),
      .ovf     (pkt_ovf_p0[q]),
      .unf     (pkt_unf_p0[q])
    );

`ifdef P4_ROUTER_QUEUE_BYTE_COUNT_EN
    logic byte_inc, byte_dec, byte_zero_unused;

    assign byte_inc = enq_evt_p0.beat && (enq_evt_p0.idx == QID);
    assign byte_dec = deq_evt_p0.beat && (deq_evt_p0.idx == QID);

    p4_router_queue_counter #(
      .WIDTH (BYTE_CNT_WIDTH),
      .AMT_W (BYTE_AMT_W)
    ) u_byte_cnt (
      .clk     (clk),
      .sreset  (sreset),
      .inc     (byte_inc),
      .dec     (byte_dec),
      .inc_amt (enq_bytes_p0),
      .dec_amt (deq_bytes_p0),
      .cnt     (queue_byte_cnt[q*BYTE_CNT_WIDTH +: BYTE_CNT_WIDTH]),
      .zero    (byte_zero_unused),
      .ovf     (byte_ovf_p0[q]),
      .unf     (byte_unf_p0[q])
    );
`endif
  end

  always_comb begin
    ovf_any_p0 = |pkt_ovf_p0;
    unf_any_p0 = |pkt_unf_p0;
`ifdef P4_ROUTER_QUEUE_BYTE_COUNT_EN
    ovf_any_p0 = ovf_any_p0 | (|byte_ovf_p0);
    unf_any_p0 = unf_any_p0 | (|byte_unf_p0);
`endif
  end

  // p0 -> p1: registered error pulses
  always_ff @(posedge clk) begin
    if (sreset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_bad_queue <= 1'b0;
    end else begin
      err_overflow  <= ovf_any_p0;
      err_underflow <= unf_any_p0;
      err_bad_queue <= bad_p0;
    end
  end

endmodule

// File: tb/tb_p4_router_queue_occupancy.sv
// Scoreboard bench for p4_router_queue_occupancy: two DUTs (12-bit and 2-bit
// packet counters) share one pair of notification streams.
module tb_p4_router_queue_occupancy;
  import p4_router_pkg::*;

  localparam int NEP = 3;
  localparam int NQ  = NEP * NUM_QUEUES_PER_EGR_PORT;
  localparam int UW  = 4;
  localparam int WA  = 12;
  localparam int WB  = 2;
  localparam int BW  = 24;

  logic clk = 1'b0;
  logic sreset = 1'b1;
  always #5 clk = ~clk;

  AXIS_int #(.DATA_WIDTH(64), .USER_WIDTH(UW)) enq_if ();
  AXIS_int #(.DATA_WIDTH(64), .USER_WIDTH(UW)) deq_if ();

  logic [NQ-1:0]    empty_a, empty_b;
  logic [NQ*WA-1:0] cnt_a;
  logic [NQ*WB-1:0] cnt_b;
  logic             ovf_a, unf_a, bad_a, ovf_b, unf_b, bad_b;
`ifdef P4_ROUTER_QUEUE_BYTE_COUNT_EN
  logic [NQ*BW-1:0] bytes_a, bytes_b;
`endif

  p4_router_queue_occupancy #(.NUM_EGR_PORTS(NEP), .PKT_CNT_WIDTH(WA), .BYTE_CNT_WIDTH(BW)) dut_a (
    .clk(clk), .sreset(sreset),
    .enqueue_notification(enq_if), .dequeue_notification(deq_if),
    .queue_empty(empty_a), .queue_pkt_cnt(cnt_a),
`ifdef P4_ROUTER_QUEUE_BYTE_COUNT_EN
    .queue_byte_cnt(bytes_a),
`endif
    .err_overflow(ovf_a), .err_underflow(unf_a), .err_bad_queue(bad_a));

  p4_router_queue_occupancy #(.NUM_EGR_PORTS(NEP), .PKT_CNT_WIDTH(WB), .BYTE_CNT_WIDTH(BW)) dut_b (
    .clk(clk), .sreset(sreset),
    .enqueue_notification(enq_if), .dequeue_notification(deq_if),
    .queue_empty(empty_b), .queue_pkt_cnt(cnt_b),
`ifdef P4_ROUTER_QUEUE_BYTE_COUNT_EN
    .queue_byte_cnt(bytes_b),
`endif
    .err_overflow(ovf_b), .err_underflow(unf_b), .err_bad_queue(bad_b));

  typedef struct {
    logic [NQ*WA-1:0] cnt_a;
    logic [NQ-1:0]    empty_a;
    logic [2:0]       err_a;
    logic [NQ*WB-1:0] cnt_b;
    logic [NQ-1:0]    empty_b;
    logic [2:0]       err_b;
    logic [NQ*BW-1:0] bytes;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_bad    = 0;
  int   m_a[NQ];
  int   m_b[NQ];
  int   m_by[NQ];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat_apply(input int c, input int d, input int mx,
                                   output bit o, output bit u);
    int n;
    n = c + d;
    o = 1'b0;
    u = 1'b0;
    if (n > mx) begin n = mx; o = 1'b1; end
    if (n < 0)  begin n = 0;  u = 1'b1; end
    return n;
  endfunction

  // Reference model: occupancy after the next clock edge, from the stream rules.
  task automatic model_step(input bit rst, input bit e_hs, input bit e_last, input int e_q,
                            input int e_n, input bit d_hs, input bit d_last, input int d_q,
                            input int d_n);
    exp_t e;
    int   dp[NQ];
    int   db[NQ];
    bit   o, u, bad, oa, ua, ob, ub;
    bad = 0; oa = 0; ua = 0; ob = 0; ub = 0;
    for (int q = 0; q < NQ; q++) begin dp[q] = 0; db[q] = 0; end
    if (e_hs && e_last) begin if (e_q < NQ) dp[e_q] += 1; else bad = 1; end
    if (d_hs && d_last) begin if (d_q < NQ) dp[d_q] -= 1; else bad = 1; end
    if (e_hs && e_q < NQ) db[e_q] += e_n;
    if (d_hs && d_q < NQ) db[d_q] -= d_n;
    if (rst) begin
      for (int q = 0; q < NQ; q++) begin m_a[q] = 0; m_b[q] = 0; m_by[q] = 0; end
      bad = 0;
    end else begin
      for (int q = 0; q < NQ; q++) begin
        m_a[q] = sat_apply(m_a[q], dp[q], (1 << WA) - 1, o, u); oa |= o; ua |= u;
        m_b[q] = sat_apply(m_b[q], dp[q], (1 << WB) - 1, o, u); ob |= o; ub |= u;
`ifdef P4_ROUTER_QUEUE_BYTE_COUNT_EN
        m_by[q] = sat_apply(m_by[q], db[q], (1 << BW) - 1, o, u);
        oa |= o; ua |= u; ob |= o; ub |= u;
`endif
      end
    end
    for (int q = 0; q < NQ; q++) begin
      e.cnt_a[q*WA +: WA] = WA'(m_a[q]);
      e.cnt_b[q*WB +: WB] = WB'(m_b[q]);
      e.bytes[q*BW +: BW] = BW'(m_by[q]);
      e.empty_a[q]        = (m_a[q] == 0);
      e.empty_b[q]        = (m_b[q] == 0);
    end
    e.err_a = {oa, ua, bad};
    e.err_b = {ob, ub, bad};
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit ev, input bit er, input bit el, input int eq,
                       input logic [7:0] ek, input bit dv, input bit dr, input bit dl,
                       input int dq, input logic [7:0] dk);
    @(negedge clk);
    sreset        = rst;
    enq_if.tvalid = ev;  enq_if.tready = er;  enq_if.tlast = el;
    enq_if.tuser  = UW'(eq); enq_if.tkeep = ek; enq_if.tdata = {$urandom, $urandom};
    deq_if.tvalid = dv;  deq_if.tready = dr;  deq_if.tlast = dl;
    deq_if.tuser  = UW'(dq); deq_if.tkeep = dk; deq_if.tdata = {$urandom, $urandom};
    model_step(rst, ev && er, el, eq, $countones(ek), dv && dr, dl, dq, $countones(dk));
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00);
  endtask
  task automatic enq1(input int q, input bit last, input logic [7:0] keep);
    drive(1'b0, 1'b1, 1'b1, last, q, keep, 1'b0, 1'b1, 1'b0, 0, 8'h00);
  endtask
  task automatic deq1(input int q, input bit last, input logic [7:0] keep);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b1, last, q, keep);
  endtask
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every registered output is valid each cycle; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mon_cnt_a",   512'(cnt_a),   512'(e.cnt_a));
        chk("mon_empty_a", 512'(empty_a), 512'(e.empty_a));
        chk("mon_err_a",   512'({ovf_a, unf_a, bad_a}), 512'(e.err_a));
        chk("mon_cnt_b",   512'(cnt_b),   512'(e.cnt_b));
        chk("mon_empty_b", 512'(empty_b), 512'(e.empty_b));
        chk("mon_err_b",   512'({ovf_b, unf_b, bad_b}), 512'(e.err_b));
`ifdef P4_ROUTER_QUEUE_BYTE_COUNT_EN
        chk("mon_bytes_a", 512'(bytes_a), 512'(e.bytes));
        chk("mon_bytes_b", 512'(bytes_b), 512'(e.bytes));
`endif
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NQ*WA-1:0] snap;
    enq_if.tvalid = 1'b0; enq_if.tready = 1'b1; enq_if.tlast = 1'b0;
    enq_if.tuser  = '0;   enq_if.tkeep  = '0;   enq_if.tdata = '0;
    deq_if.tvalid = 1'b0; deq_if.tready = 1'b1; deq_if.tlast = 1'b0;
    deq_if.tuser  = '0;   deq_if.tkeep  = '0;   deq_if.tdata = '0;

    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4, 8'hFF, 1'b0, 1'b1, 1'b0, 0, 8'h00);
    settle();
    chk("reset_empty", 512'(empty_a), 512'({NQ{1'b1}}));
    chk("reset_cnt",   512'(cnt_a),   512'(0));

    // Three single-beat packets to queue 5
    for (int i = 0; i < 3; i++) begin
      enq1(5, 1'b1, 8'hFF);
      settle();
      chk("q5_cnt",   512'(cnt_a[5*WA +: WA]), 512'(i + 1));
      chk("q5_empty", 512'(empty_a[5]),        512'(0));
    end

    // Four-beat packet to queue 2
    for (int i = 0; i < 4; i++) begin
      enq1(2, i == 3, 8'hFF);
      settle();
      chk("q2_multibeat", 512'(cnt_a[2*WA +: WA]), 512'((i == 3) ? 1 : 0));
    end

    // Same-queue enqueue and dequeue nets out
    enq1(1, 1'b1, 8'h0F);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1, 8'h0F, 1'b1, 1'b1, 1'b1, 1, 8'h0F);
    settle();
    chk("q1_net_cnt", 512'(cnt_a[1*WA +: WA]), 512'(1));
    chk("q1_net_err", 512'({ovf_a, unf_a, bad_a}), 512'(0));

    // Underflow on empty queue 0
    deq1(0, 1'b1, 8'h01);
    settle();
    chk("q0_unf_cnt",   512'(cnt_a[0*WA +: WA]), 512'(0));
    chk("q0_unf_pulse", 512'(unf_a), 512'(1));
    idle();
    settle();
    chk("q0_unf_clear", 512'(unf_a), 512'(0));

    // Overflow on the 2-bit DUT at queue 3
    for (int i = 0; i < 4; i++) begin
      enq1(3, 1'b1, 8'h03);
      settle();
      chk("q3_b_cnt", 512'(cnt_b[3*WB +: WB]), 512'((i < 3) ? i + 1 : 3));
      chk("q3_b_ovf", 512'(ovf_b), 512'((i == 3) ? 1 : 0));
      chk("q3_a_cnt", 512'(cnt_a[3*WA +: WA]), 512'(i + 1));
    end
    idle();
    settle();
    chk("q3_b_ovf_clear", 512'(ovf_b), 512'(0));

    // Out-of-range queue index
    snap = cnt_a;
    enq1(NQ, 1'b1, 8'hFF);
    settle();
    chk("badq_pulse", 512'(bad_a), 512'(1));
    chk("badq_cnt",   512'(cnt_a), 512'(snap));
    idle();
    settle();
    chk("badq_clear", 512'(bad_a), 512'(0));

    // Reset mid-stream with live events
    enq1(6, 1'b1, 8'hFF);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 6, 8'hFF, 1'b1, 1'b1, 1'b1, 5, 8'hFF);
    settle();
    chk("midrst_empty", 512'(empty_a), 512'({NQ{1'b1}}));
    chk("midrst_cnt",   512'(cnt_a),   512'(0));
    idle();

`ifdef P4_ROUTER_QUEUE_BYTE_COUNT_EN
    enq1(7, 1'b0, 8'hFF);
    settle();
    chk("bytes_8", 512'(bytes_a[7*BW +: BW]), 512'(8));
    enq1(7, 1'b1, 8'h07);
    settle();
    chk("bytes_11", 512'(bytes_a[7*BW +: BW]), 512'(11));
    deq1(7, 1'b0, 8'hFF);
    settle();
    chk("bytes_3", 512'(bytes_a[7*BW +: BW]), 512'(3));
    deq1(7, 1'b1, 8'h07);
    settle();
    chk("bytes_0", 512'(bytes_a[7*BW +: BW]), 512'(0));
`endif

    // Randomized traffic, including bad indices, same-queue collisions and rare resets
    for (int i = 0; i < 3000; i++) begin
      int eq, dq;
      eq = $urandom_range(0, NQ + 1);
      dq = ($urandom_range(0, 3) == 0) ? eq : $urandom_range(0, NQ + 1);
      drive($urandom_range(0, 299) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            eq, 8'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            dq, 8'($urandom));
    end
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
